// File: rtl/pit_ctrl_pkg.sv
// Shared types and widths for the PIT request arbiter slice.
package pit_ctrl_pkg;

    localparam int PREFIX_W          = 64;
    localparam int META_W            = 8;
    localparam int LEN_W             = 6;
    localparam int ENTRY_W           = 11;
    localparam int META_INTEREST_BIT = 6;

    localparam int SPI_SLOT_W = PREFIX_W + LEN_W;
    localparam int FIB_SLOT_W = PREFIX_W + META_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        SIDE_SPI = 1'b0,
        SIDE_FIB = 1'b1
    } side_e;

    function automatic side_e other_side(input side_e s);
        return (s == SIDE_SPI) ? SIDE_FIB : SIDE_SPI;
    endfunction

endpackage

// File: rtl/pit_req_slot.sv
// One-entry valid/ready holding register; ready simply means the slot is empty.
module pit_req_slot #(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_r;
    logic [W-1:0] data_r;

    // Capture on handshake; release when the slot's response goes out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            data_r <= {W{1'b0}};
        end else if (in_valid && !full_r) begin
            full_r <= 1'b1;
            data_r <= in_data;
        end else if (clear) begin
            full_r <= 1'b0;
        end
    end

    assign in_ready = ~full_r;
    assign full     = full_r;
    assign data     = data_r;

endmodule

// File: rtl/pit_request_arbiter.sv
// Shares the PIT between the SPI interest path and the FIB data path, one lookup at a time.
module pit_request_arbiter
    import pit_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_req_valid,
    output logic                spi_req_ready,
    input  logic [PREFIX_W-1:0] spi_req_prefix,
    input  logic [LEN_W-1:0]    spi_req_length,
    input  logic                fib_req_valid,
    output logic                fib_req_ready,
    input  logic [PREFIX_W-1:0] fib_req_prefix,
    input  logic [META_W-1:0]   fib_req_meta,
    output logic                pit_out_bit,
    output logic                pit_prefix_ready,
    output logic [PREFIX_W-1:0] pit_spi_prefix,
    output logic [LEN_W-1:0]    pit_spi_length,
    output logic [PREFIX_W-1:0] pit_fib_prefix,
    output logic [META_W-1:0]   pit_fib_meta,
    input  logic                pit_in_bit,
    input  logic                pit_rejected,
    input  logic [ENTRY_W-1:0]  pit_table_entry,
    input  logic                pit_interest_packet,
    output logic                spi_resp_valid,
    output logic                fib_resp_valid,
    output logic [ENTRY_W-1:0]  resp_entry,
    output logic                resp_rejected,
    output logic                resp_interest,
    output logic                resp_timeout,
    output logic                busy
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    logic                  spi_full_s, fib_full_s, spi_clr_s, fib_clr_s;
    logic [SPI_SLOT_W-1:0] spi_data_s;
    logic [FIB_SLOT_W-1:0] fib_data_s;
    state_e                state_r, state_nx_s;
    side_e                 grant_r, grant_nx_s, rr_pri_r, rr_pri_nx_s;
    logic [7:0]            cnt_r;
    logic                  base_in_r, base_rej_r, prev_in_r, prev_rej_r;
    logic                  done_s, timeout_s;
    logic                  pit_out_bit_r, pit_prefix_ready_r, busy_r;
    logic                  spi_resp_valid_r, fib_resp_valid_r;
    logic [ENTRY_W-1:0]    resp_entry_r;
    logic                  resp_rejected_r, resp_interest_r, resp_timeout_r;

    assign spi_clr_s = (state_r == RESP) && (grant_r == SIDE_SPI);
    assign fib_clr_s = (state_r == RESP) && (grant_r == SIDE_FIB);

    pit_req_slot #(.W(SPI_SLOT_W)) u_spi_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (spi_req_valid),
        .in_ready (spi_req_ready),
        .in_data  ({spi_req_length, spi_req_prefix}),
        .clear    (spi_clr_s),
        .full     (spi_full_s),
        .data     (spi_data_s)
    );

    pit_req_slot #(.W(FIB_SLOT_W)) u_fib_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (fib_req_valid),
        .in_ready (fib_req_ready),
        .in_data  ({fib_req_meta, fib_req_prefix}),
        .clear    (fib_clr_s),
        .full     (fib_full_s),
        .data     (fib_data_s)
    );

    assign pit_spi_prefix = spi_data_s[PREFIX_W-1:0];
    assign pit_spi_length = spi_data_s[SPI_SLOT_W-1:PREFIX_W];
    assign pit_fib_prefix = fib_data_s[PREFIX_W-1:0];
    assign pit_fib_meta   = fib_data_s[FIB_SLOT_W-1:PREFIX_W];

    // Completion: a fresh rise since last cycle, or a high level against a low baseline
    always_comb begin
        done_s    = 1'b0;
        timeout_s = 1'b0;
        if (state_r == WAIT) begin
            done_s    = (pit_in_bit && (!prev_in_r || !base_in_r)) ||
                        (pit_rejected && (!prev_rej_r || !base_rej_r));
            timeout_s = !done_s && (cnt_r == TIMEOUT_LIM);
        end else begin
            done_s    = 1'b0;
            timeout_s = 1'b0;
        end
    end

    // Next state, grant selection and round-robin pointer
    always_comb begin
        state_nx_s  = state_r;
        grant_nx_s  = grant_r;
        rr_pri_nx_s = rr_pri_r;
        case (state_r)
            IDLE: begin
                if (spi_full_s && fib_full_s) begin
                    grant_nx_s = rr_pri_r;
                    state_nx_s = ISSUE;
                end else if (spi_full_s) begin
                    grant_nx_s = SIDE_SPI;
                    state_nx_s = ISSUE;
                end else if (fib_full_s) begin
                    grant_nx_s = SIDE_FIB;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
                if (spi_full_s || fib_full_s) begin
                    rr_pri_nx_s = other_side(grant_nx_s);
                end else begin
                    rr_pri_nx_s = rr_pri_r;
                end
            end
            ISSUE: state_nx_s = WAIT;
            WAIT: begin
                if (done_s || timeout_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Sequencer state, strobes, baseline and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= IDLE;
            grant_r            <= SIDE_SPI;
            rr_pri_r           <= SIDE_SPI;
            pit_out_bit_r      <= 1'b0;
            pit_prefix_ready_r <= 1'b0;
            busy_r             <= 1'b0;
            base_in_r          <= 1'b0;
            base_rej_r         <= 1'b0;
            prev_in_r          <= 1'b0;
            prev_rej_r         <= 1'b0;
            cnt_r              <= 8'd0;
        end else begin
            state_r            <= state_nx_s;
            grant_r            <= grant_nx_s;
            rr_pri_r           <= rr_pri_nx_s;
            pit_out_bit_r      <= (state_nx_s == ISSUE) && (grant_nx_s == SIDE_SPI);
            pit_prefix_ready_r <= (state_nx_s == ISSUE) && (grant_nx_s == SIDE_FIB);
            busy_r             <= (state_nx_s != IDLE);
            prev_in_r          <= pit_in_bit;
            prev_rej_r         <= pit_rejected;
            if (state_r == ISSUE) begin
                base_in_r  <= pit_in_bit;
                base_rej_r <= pit_rejected;
            end
            cnt_r <= (state_r == WAIT) ? cnt_r + 8'd1 : 8'd0;
        end
    end

    // Response capture; fields hold until the next lookup finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_resp_valid_r <= 1'b0;
            fib_resp_valid_r <= 1'b0;
            resp_entry_r     <= {ENTRY_W{1'b0}};
            resp_rejected_r  <= 1'b0;
            resp_interest_r  <= 1'b0;
            resp_timeout_r   <= 1'b0;
        end else begin
            spi_resp_valid_r <= (done_s || timeout_s) && (grant_r == SIDE_SPI);
            fib_resp_valid_r <= (done_s || timeout_s) && (grant_r == SIDE_FIB);
            if (done_s) begin
                resp_entry_r    <= pit_table_entry;
                resp_rejected_r <= pit_rejected;
                resp_interest_r <= (grant_r == SIDE_FIB) ? pit_interest_packet : 1'b0;
                resp_timeout_r  <= 1'b0;
            end else if (timeout_s) begin
                resp_entry_r    <= {ENTRY_W{1'b0}};
                resp_rejected_r <= 1'b0;
                resp_interest_r <= 1'b0;
                resp_timeout_r  <= 1'b1;
            end
        end
    end

    assign pit_out_bit      = pit_out_bit_r;
    assign pit_prefix_ready = pit_prefix_ready_r;
    assign busy             = busy_r;
    assign spi_resp_valid   = spi_resp_valid_r;
    assign fib_resp_valid   = fib_resp_valid_r;
    assign resp_entry       = resp_entry_r;
    assign resp_rejected    = resp_rejected_r;
    assign resp_interest    = resp_interest_r;
    assign resp_timeout     = resp_timeout_r;

endmodule

// File: tb/tb_pit_request_arbiter.sv
// Scoreboard bench: bench plays both requesters and the PIT, predicts every grant and response.
module tb_pit_request_arbiter;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_req_valid = 1'b0, fib_req_valid = 1'b0;
    logic        spi_req_ready, fib_req_ready;
    logic [63:0] spi_req_prefix = 64'h0, fib_req_prefix = 64'h0;
    logic [5:0]  spi_req_length = 6'h0;
    logic [7:0]  fib_req_meta = 8'h0;
    logic        pit_out_bit, pit_prefix_ready;
    logic [63:0] pit_spi_prefix, pit_fib_prefix;
    logic [5:0]  pit_spi_length;
    logic [7:0]  pit_fib_meta;
    logic        pit_in_bit = 1'b0, pit_rejected = 1'b0, pit_interest_packet = 1'b0;
    logic [10:0] pit_table_entry = 11'h0;
    logic        spi_resp_valid, fib_resp_valid, resp_rejected, resp_interest, resp_timeout, busy;
    logic [10:0] resp_entry;

    pit_request_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_req_valid(spi_req_valid), .spi_req_ready(spi_req_ready),
        .spi_req_prefix(spi_req_prefix), .spi_req_length(spi_req_length),
        .fib_req_valid(fib_req_valid), .fib_req_ready(fib_req_ready),
        .fib_req_prefix(fib_req_prefix), .fib_req_meta(fib_req_meta),
        .pit_out_bit(pit_out_bit), .pit_prefix_ready(pit_prefix_ready),
        .pit_spi_prefix(pit_spi_prefix), .pit_spi_length(pit_spi_length),
        .pit_fib_prefix(pit_fib_prefix), .pit_fib_meta(pit_fib_meta),
        .pit_in_bit(pit_in_bit), .pit_rejected(pit_rejected),
        .pit_table_entry(pit_table_entry), .pit_interest_packet(pit_interest_packet),
        .spi_resp_valid(spi_resp_valid), .fib_resp_valid(fib_resp_valid),
        .resp_entry(resp_entry), .resp_rejected(resp_rejected),
        .resp_interest(resp_interest), .resp_timeout(resp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        bit          side;
        logic [10:0] entry;
        bit          rej;
        bit          intr;
        bit          tmo;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [69:0] spi_sent_q[$];
    logic [71:0] fib_sent_q[$];
    bit          spi_has = 0, fib_has = 0, rr_m = 0;
    int          spi_from = 0, fib_from = 0;

    // PIT behaviour: -1 random, 0 hit, 1 rejected, 2 never answers (timeout), 3 silent/no expectation
    int          dir_kind = -1, dir_delay = 1;
    logic [10:0] dir_entry = 11'h0;
    bit          dir_intr = 0;

    int          drive_at = -1, ready_chk_cyc = -1, kind, d;
    bit          drv_rej, drv_intr, ready_chk_side, pend_s, pend_f, exp_side, intr;
    logic [10:0] drv_entry, ent;
    exp_t        e;

    // Monitor, PIT responder and reference model, all evaluated away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pit_in_bit = 0; pit_rejected = 0; pit_interest_packet = 0; pit_table_entry = 11'h0;
            drive_at = -1; ready_chk_cyc = -1;
            exp_q.delete(); spi_sent_q.delete(); fib_sent_q.delete();
            spi_has = 0; fib_has = 0; rr_m = 0;
        end else begin
            if (cyc == drive_at) begin
                pit_in_bit = !drv_rej; pit_rejected = drv_rej;
                pit_table_entry = drv_entry; pit_interest_packet = drv_intr;
            end else if (cyc == drive_at + 1) begin
                pit_in_bit = 0; pit_rejected = 0; pit_interest_packet = 0; pit_table_entry = 11'h0;
            end
            if (spi_req_valid && spi_req_ready) begin
                spi_has = 1; spi_from = cyc + 1; spi_sent_q.push_back({spi_req_length, spi_req_prefix});
            end
            if (fib_req_valid && fib_req_ready) begin
                fib_has = 1; fib_from = cyc + 1; fib_sent_q.push_back({fib_req_meta, fib_req_prefix});
            end
            if (cyc == ready_chk_cyc)
                chk(ready_chk_side ? "fib_ready_after_resp" : "spi_ready_after_resp",
                    ready_chk_side ? fib_req_ready : spi_req_ready, 1);
            if (pit_out_bit || pit_prefix_ready) begin
                chk("strobe_exclusive", pit_out_bit & pit_prefix_ready, 0);
                pend_s = spi_has && (spi_from <= cyc - 1);
                pend_f = fib_has && (fib_from <= cyc - 1);
                if (!pend_s && !pend_f) begin
                    n_cmp++; n_bad++;
                    $display("FAIL strobe_unexpected: got strobe spi=%0b fib=%0b expected none (cycle %0d)",
                             pit_out_bit, pit_prefix_ready, cyc);
                end else begin
                    exp_side = (pend_s && pend_f) ? rr_m : pend_f;
                    chk("grant_side", pit_prefix_ready, exp_side);
                    rr_m = !exp_side;
                    if (exp_side) begin
                        fib_has = 0;
                        if (fib_sent_q.size() > 0) chk("fib_payload", {pit_fib_meta, pit_fib_prefix}, fib_sent_q.pop_front());
                    end else begin
                        spi_has = 0;
                        if (spi_sent_q.size() > 0) chk("spi_payload", {pit_spi_length, pit_spi_prefix}, spi_sent_q.pop_front());
                    end
                    if (dir_kind >= 0) begin
                        kind = dir_kind; d = dir_delay; ent = dir_entry; intr = dir_intr;
                    end else begin
                        kind = $urandom_range(0, 9);
                        kind = (kind >= 6 && kind <= 7) ? 1 : (kind == 8) ? 2 : 0;
                        d = $urandom_range(1, 6); ent = 11'($urandom); intr = 1'($urandom);
                    end
                    if (kind == 2) begin
                        exp_q.push_back('{exp_side, 11'h0, 1'b0, 1'b0, 1'b1, cyc + T + 2});
                    end else if (kind != 3) begin
                        drive_at = cyc + d; drv_rej = (kind == 1); drv_entry = ent; drv_intr = intr;
                        exp_q.push_back('{exp_side, ent, kind == 1, exp_side ? intr : 1'b0, 1'b0, cyc + d + 1});
                    end
                end
            end
            if (spi_resp_valid || fib_resp_valid) begin
                chk("resp_exclusive", spi_resp_valid & fib_resp_valid, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL resp_unexpected: got pulse spi=%0b fib=%0b expected none (cycle %0d)",
                             spi_resp_valid, fib_resp_valid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_side", fib_resp_valid, e.side);
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_fields", {resp_entry, resp_rejected, resp_interest, resp_timeout},
                        {e.entry, e.rej, e.intr, e.tmo});
                    chk("slot_full_during_resp", e.side ? fib_req_ready : spi_req_ready, 0);
                    ready_chk_cyc = cyc + 1; ready_chk_side = e.side;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                n_cmp++; n_bad++;
                $display("FAIL resp_missing: got no pulse expected one at cycle %0d", exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_spi(input logic [63:0] p, input logic [5:0] l);
        int n = 0;
        @(posedge clk); #1;
        spi_req_prefix = p; spi_req_length = l; spi_req_valid = 1;
        do begin @(negedge clk); n++; end while (!spi_req_ready && n < 400);
        if (!spi_req_ready) chk("spi_accept_bound", 0, 1);
        @(posedge clk); #1 spi_req_valid = 0;
    endtask

    task automatic send_fib(input logic [63:0] p, input logic [7:0] m);
        int n = 0;
        @(posedge clk); #1;
        fib_req_prefix = p; fib_req_meta = m; fib_req_valid = 1;
        do begin @(negedge clk); n++; end while (!fib_req_ready && n < 400);
        if (!fib_req_ready) chk("fib_accept_bound", 0, 1);
        @(posedge clk); #1 fib_req_valid = 0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((spi_has || fib_has || exp_q.size() != 0) && n < 800) begin @(negedge clk); n++; end
        if (n >= 800) chk("quiet_bound", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_pit(input int k, input int dl, input logic [10:0] en, input bit it);
        dir_kind = k; dir_delay = dl; dir_entry = en; dir_intr = it;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pit_out_bit, pit_prefix_ready, spi_resp_valid, fib_resp_valid, resp_entry,
            resp_rejected, resp_interest, resp_timeout, busy, spi_req_ready, fib_req_ready,
            pit_spi_prefix, pit_fib_prefix}, {4'b0, 11'h0, 4'b0, 2'b11, 64'h0, 64'h0});
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        chk("idle_after_release", {busy, spi_req_ready, fib_req_ready}, 3'b011);

        set_pit(0, 2, 11'h005, 0);
        send_spi(64'h0123_4567_89AB_CDEF, 6'd12);
        wait_quiet();

        for (int r = 0; r < 2; r++) begin
            set_pit(0, 1 + r, 11'h111 + 11'(r), 1);
            fork
                send_spi({$urandom, $urandom}, 6'($urandom));
                send_fib({$urandom, $urandom}, 8'($urandom));
            join
            wait_quiet();
        end

        set_pit(1, 3, 11'h0AA, 0);
        send_fib(64'hFEED_F00D_0000_0001, 8'h00);
        wait_quiet();
        set_pit(0, 2, 11'h402, 1);
        send_fib(64'hFEED_F00D_0000_0002, 8'h40);
        wait_quiet();
        set_pit(1, 2, 11'h3C3, 0);
        send_spi(64'h1111_2222_3333_4444, 6'd63);
        wait_quiet();

        set_pit(2, 1, 11'h0, 0);
        fork
            send_spi(64'hAAAA_0000_0000_0001, 6'd1);
            begin @(negedge clk); send_fib(64'hBBBB_0000_0000_0002, 8'hFF); end
        join
        wait_quiet();

        dir_kind = -1;
        fork
            repeat (20) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                send_spi({$urandom, $urandom}, 6'($urandom));
            end
            repeat (20) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                send_fib({$urandom, $urandom}, 8'($urandom));
            end
        join
        wait_quiet();

        set_pit(3, 1, 11'h0, 0);
        send_spi(64'hDEAD_BEEF_0000_0000, 6'd5);
        begin
            int n = 0;
            while (spi_has && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) chk("strobe_bound", 0, 1);
        end
        repeat (3) @(negedge clk);
        chk("busy_in_wait", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("async_reset_outputs", {pit_out_bit, pit_prefix_ready, spi_resp_valid, fib_resp_valid, resp_entry,
            resp_rejected, resp_interest, resp_timeout, busy, spi_req_ready, fib_req_ready,
            pit_spi_prefix, pit_fib_prefix}, {4'b0, 11'h0, 4'b0, 2'b11, 64'h0, 64'h0});
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("ready_after_reset", {spi_req_ready, fib_req_ready}, 2'b11);
        repeat (30) @(negedge clk);

        set_pit(0, 2, 11'h7FF, 1);
        send_fib(64'h0F0F_0F0F_0F0F_0F0F, 8'h40);
        wait_quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
